// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg -- shared definitions for the 16-bit pipelined CPU.
//
// Contents:
//   INSTR_W / ADDR_W      instruction and address widths
//   OPC_MSB / OPC_LSB     position of the opcode field inside an instruction
//   R_FMT .. BEQ          opcode constants
//   fetchState_t          instruction-fetch FSM state encoding
//   opcodeOf()            extracts the opcode field
//   alignPc()             forces an address to a halfword boundary
//   pcPlus2()             sequential next PC, modulo 2^16
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    localparam logic [3:0] R_FMT = 4'b0000;
    localparam logic [3:0] ADDI  = 4'b0001;
    localparam logic [3:0] SUBI  = 4'b0010;
    localparam logic [3:0] SLTI  = 4'b0011;
    localparam logic [3:0] LW    = 4'b0100;
    localparam logic [3:0] SW    = 4'b0101;
    localparam logic [3:0] BEQ   = 4'b0110;

    typedef enum logic [1:0] {
        BOOT     = 2'b00,
        FETCH    = 2'b01,
        REDIRECT = 2'b10
    } fetchState_t;

    function automatic logic [3:0] opcodeOf(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    // Instructions are halfword aligned, so bit 0 of any PC is always zero.
    function automatic logic [ADDR_W-1:0] alignPc(input logic [ADDR_W-1:0] addr);
        return addr & 16'hFFFE;
    endfunction

    // Plain 16-bit add; the carry out is dropped so 16'hFFFE wraps to 16'h0000.
    function automatic logic [ADDR_W-1:0] pcPlus2(input logic [ADDR_W-1:0] pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if -- instruction memory request/response bus.
//
// Signals:
//   IMemReq    fetch request (fetch stage -> memory)
//   IMemAddr   fetch address (fetch stage -> memory)
//   IMemReady  acknowledge; IMemData is valid in the same cycle (memory -> fetch)
//   IMemData   instruction word (memory -> fetch)
// Modports:
//   master     the fetch stage
//   slave      the instruction memory
// -----------------------------------------------------------------------------
interface instruction_fetch_if;
    import cpu_pkg::*;

    logic               IMemReq;
    logic [ADDR_W-1:0]  IMemAddr;
    logic               IMemReady;
    logic [INSTR_W-1:0] IMemData;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemReady,
        input  IMemData
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemReady,
        output IMemData
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// -----------------------------------------------------------------------------
// fetch_pc_reg -- program counter register and next-PC selection.
//
// Parameters:
//   RESET_PC     value loaded while Reset is high (bit 0 forced to zero)
// Ports:
//   Clock        rising-edge clock
//   Reset        asynchronous, active-high reset
//   loadTarget   load the redirect address (highest priority after Reset)
//   advance      step to PC+2 (a fetch completed this cycle)
//   target       redirect address
//   pc           current program counter, always halfword aligned
// -----------------------------------------------------------------------------
module fetch_pc_reg
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              loadTarget,
    input  logic              advance,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] nextPc_s;

    // Next-PC mux: redirect beats sequential advance; otherwise hold.
    always_comb begin
        nextPc_s = pc_r;
        if (loadTarget) begin
            nextPc_s = alignPc(target);
        end else if (advance) begin
            nextPc_s = alignPc(pcPlus2(pc_r));
        end else begin
            nextPc_s = pc_r;
        end
    end

    // PC register with asynchronous reset to the aligned reset vector.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc_r <= alignPc(RESET_PC);
        end else begin
            pc_r <= nextPc_s;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch -- IF stage of the 16-bit pipeline: PC, fetch FSM and the
// IF/ID pipeline register.
//
// Parameters:
//   RESET_PC      PC value loaded on reset
// Ports:
//   Clock         rising-edge clock
//   Reset         asynchronous, active-high reset
//   Stall         hazard hold from decode; freezes PC and IF/ID
//   BranchTaken   BEQ resolved taken; redirects fetch
//   BranchTarget  redirect address
//   imem          instruction memory bus (master side)
//   IFID_Instr    IF/ID instruction word
//   IFID_PCPlus2  IF/ID address of the following instruction
//   IFID_Valid    IF/ID holds a real instruction
//   OPCODE        IFID_Instr[15:12] for the control unit (combinational)
//   FetchCount    completed fetches, wraps       (IFETCH_PERF_CNT_EN only)
//   StallCount    cycles held by Stall, wraps    (IFETCH_PERF_CNT_EN only)
//
// Build option: define IFETCH_PERF_CNT_EN to add the performance counters.
//
// Priority each cycle: Reset > BranchTaken > Stall > fetch.
// -----------------------------------------------------------------------------
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Stall,
    input  logic               BranchTaken,
    input  logic [ADDR_W-1:0]  BranchTarget,
    instruction_fetch_if.master imem,
    output logic [INSTR_W-1:0] IFID_Instr,
    output logic [ADDR_W-1:0]  IFID_PCPlus2,
    output logic               IFID_Valid,
    output logic [3:0]         OPCODE
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [15:0]        FetchCount,
    output logic [15:0]        StallCount
`endif
);

    fetchState_t        state_r;
    logic [INSTR_W-1:0] ifidInstr_r;
    logic [ADDR_W-1:0]  ifidPcPlus2_r;
    logic               ifidValid_r;
    logic [ADDR_W-1:0]  pc_s;
    logic               fetchFire_s;

    // A fetch completes only in FETCH, with memory ready and nothing overriding it.
    assign fetchFire_s = (state_r == FETCH) && imem.IMemReady && !Stall && !BranchTaken;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pcReg (
        .Clock      (Clock),
        .Reset      (Reset),
        .loadTarget (BranchTaken),
        .advance    (fetchFire_s),
        .target     (BranchTarget),
        .pc         (pc_s)
    );

    // Fetch FSM and IF/ID pipeline register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r       <= BOOT;
            ifidInstr_r   <= 16'h0000;
            ifidPcPlus2_r <= 16'h0000;
            ifidValid_r   <= 1'b0;
        end else if (BranchTaken) begin
            // Any data returned this cycle belongs to the wrong path: squash it.
            state_r       <= REDIRECT;
            ifidInstr_r   <= 16'h0000;
            ifidPcPlus2_r <= ifidPcPlus2_r;
            ifidValid_r   <= 1'b0;
        end else begin
            case (state_r)
                BOOT: begin
                    state_r       <= FETCH;
                    ifidInstr_r   <= ifidInstr_r;
                    ifidPcPlus2_r <= ifidPcPlus2_r;
                    ifidValid_r   <= ifidValid_r;
                end
                FETCH: begin
                    state_r <= FETCH;
                    if (Stall) begin
                        ifidInstr_r   <= ifidInstr_r;
                        ifidPcPlus2_r <= ifidPcPlus2_r;
                        ifidValid_r   <= ifidValid_r;
                    end else if (imem.IMemReady) begin
                        ifidInstr_r   <= imem.IMemData;
                        ifidPcPlus2_r <= pcPlus2(pc_s);
                        ifidValid_r   <= 1'b1;
                    end else begin
                        // Memory not ready: insert a bubble, PC holds.
                        ifidInstr_r   <= ifidInstr_r;
                        ifidPcPlus2_r <= ifidPcPlus2_r;
                        ifidValid_r   <= 1'b0;
                    end
                end
                REDIRECT: begin
                    state_r       <= FETCH;
                    ifidInstr_r   <= ifidInstr_r;
                    ifidPcPlus2_r <= ifidPcPlus2_r;
                    if (Stall) begin
                        ifidValid_r <= ifidValid_r;
                    end else begin
                        ifidValid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= BOOT;
                    ifidInstr_r   <= 16'h0000;
                    ifidPcPlus2_r <= 16'h0000;
                    ifidValid_r   <= 1'b0;
                end
            endcase
        end
    end

    // Request is withdrawn combinationally so a stalled or redirected cycle never fetches.
    assign imem.IMemReq  = (state_r == FETCH) && !Stall && !BranchTaken;
    assign imem.IMemAddr = pc_s;

    assign IFID_Instr   = ifidInstr_r;
    assign IFID_PCPlus2 = ifidPcPlus2_r;
    assign IFID_Valid   = ifidValid_r;
    assign OPCODE       = opcodeOf(ifidInstr_r);

`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] fetchCount_r;
    logic [15:0] stallCount_r;

    // Free-running performance counters; both wrap naturally at 16'hFFFF.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            fetchCount_r <= 16'h0000;
            stallCount_r <= 16'h0000;
        end else begin
            if (fetchFire_s) begin
                fetchCount_r <= fetchCount_r + 16'd1;
            end else begin
                fetchCount_r <= fetchCount_r;
            end
            if (Stall && !BranchTaken) begin
                stallCount_r <= stallCount_r + 16'd1;
            end else begin
                stallCount_r <= stallCount_r;
            end
        end
    end

    assign FetchCount = fetchCount_r;
    assign StallCount = stallCount_r;
`endif

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 SHALL have port Clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port Stall, input, 1 bit: hazard hold from decode; freezes the PC and the IF/ID register.
REQ-005 SHALL have port BranchTaken, input, 1 bit: a BEQ resolved taken; redirects fetch.
REQ-006 SHALL have port BranchTarget, input, 16 bits: redirect address.
REQ-007 SHALL have port IMemReq, output, 1 bit: fetch request.
REQ-008 SHALL have port IMemAddr, output, 16 bits: fetch address, always equal to PC.
REQ-009 SHALL have port IMemReady, input, 1 bit: memory acknowledge; IMemData is valid in the same cycle.
REQ-010 SHALL have port IMemData, input, 16 bits: instruction word.
REQ-011 SHALL have ports IFID_Instr (16 bits), IFID_PCPlus2 (16 bits) and IFID_Valid (1 bit), all outputs: the IF/ID pipeline register.
REQ-012 SHALL have port OPCODE, output, 4 bits: IFID_Instr[15:12], combinational; feeds the control unit.

Function
REQ-013 SHALL implement FSM states BOOT, FETCH and REDIRECT.
REQ-014 SHALL hold IMemReq=0 in BOOT and move BOOT->FETCH unconditionally after one cycle.
REQ-015 SHALL drive IMemReq = !Stall && !BranchTaken in FETCH.
REQ-016 SHALL, in FETCH with IMemReady=1, Stall=0 and BranchTaken=0, load IFID_Instr<=IMemData, IFID_PCPlus2<=PC+2 and IFID_Valid<=1, and set PC<=PC+2 (one-cycle fetch latency).
REQ-017 SHALL, in FETCH with IMemReady=0, Stall=0 and BranchTaken=0, load IFID_Valid<=0 (bubble) and hold the PC.
REQ-018 SHALL, when Stall=1 and BranchTaken=0, hold the PC and all IF/ID fields unchanged, including IFID_Valid.
REQ-019 SHALL, when BranchTaken=1 in any state, set PC<=BranchTarget, IFID_Valid<=0 and IFID_Instr<=16'h0000, discard any IMemData in that cycle, and go to REDIRECT.
REQ-020 SHALL hold IMemReq=0 and IFID_Valid=0 in REDIRECT, then go to FETCH after one cycle, or stay in REDIRECT if BranchTaken=1 again.
REQ-021 SHALL apply priority Reset > BranchTaken > Stall > fetch.
REQ-022 SHALL compute PC+2 modulo 2^16: 16'hFFFE wraps to 16'h0000.
REQ-023 SHALL force PC bit 0 to 0 on every load, including BranchTarget loads.

Reset
REQ-024 SHALL, on Reset=1, immediately set PC=RESET_PC, state=BOOT, IFID_Instr=16'h0000, IFID_PCPlus2=16'h0000 and IFID_Valid=0, giving IMemReq=0 and OPCODE=4'b0000.
REQ-025 SHALL drop any in-flight fetch when Reset is asserted mid-operation, and restart from BOOT on the first edge after Reset deasserts.

Configuration
REQ-026 SHALL, when IFETCH_PERF_CNT_EN is defined, add outputs FetchCount[15:0] and StallCount[15:0]; both reset to 0, increment per REQ-016 fetch and per stalled cycle respectively, and wrap at 16'hFFFF->0.
REQ-027 SHALL, when IFETCH_PERF_CNT_EN is undefined, omit those ports and counters entirely, with functional behaviour otherwise identical.

Structure
REQ-028 SHALL take INSTR_W=16, the opcode field position [15:12], the opcode constants (R_FMT, ADDI, SUBI, SLTI, LW, SW, BEQ) and the FSM state encoding from the shared package cpu_pkg.
REQ-029 SHALL isolate the PC register and next-PC selection in the sub-module fetch_pc_reg.

Verification
REQ-030 SHALL test: reset with RESET_PC=16'h0010 and IMemReady tied to 1 -> IMemAddr sequence 0010, 0012, 0014; first IFID_Valid=1 two edges after Reset release.
REQ-031 SHALL test: IMemData=16'hC123 fetched at 0010 -> IFID_Instr=C123, OPCODE=4'b1100, IFID_PCPlus2=0012.
REQ-032 SHALL test: Stall held 3 cycles -> PC, IFID_Instr and IFID_Valid unchanged and IMemReq=0 throughout; fetch resumes at the same address.
REQ-033 SHALL test: BranchTaken=1 with BranchTarget=16'h0041 and IMemReady=1 in the same cycle -> data discarded, IFID_Valid=0 for two cycles, next IMemAddr=0040.
REQ-034 SHALL test: PC=16'hFFFE fetched -> IFID_PCPlus2=0000 and next IMemAddr=0000.
REQ-035 SHALL test: Reset asserted mid-stall -> outputs reach their reset values without a clock edge.
